// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
// State encoding is fixed so that a two-bit state value read in a waveform is unambiguous.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_e;

  // A zero or oversize length means "send the whole pattern register".
  function automatic int unsigned normalise_len(input int unsigned len,
                                                input int unsigned pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shadow register with a down-counting bit index.
// The serial output is registered and shows bit idx_q of the shadow pattern.
module seq_piso
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             capture_i,
  input  logic             reload_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             ser_o,
  output logic             last_bit_o
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             ser_q, ser_d;

  // Shift instead of a variable part-select so the index width need not match log2(PAT_W).
  function automatic logic bit_at(input logic [PAT_W-1:0] v, input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    idx_d = idx_q;
    ser_d = 1'b0;
    if (capture_i) begin
      pat_d = pat_i;
      len_d = len_i;
      idx_d = len_i - LEN_W'(1);
      ser_d = bit_at(pat_i, idx_d);
    end else if (reload_i) begin
      idx_d = len_q - LEN_W'(1);
      ser_d = bit_at(pat_q, idx_d);
    end else if (shift_i) begin
      idx_d = idx_q - LEN_W'(1);
      ser_d = bit_at(pat_q, idx_d);
    end
  end

  // NOTE: non-blocking assignments for all state; the shadow pattern is reset too
  // because it is small and a known value keeps post-reset waveforms clean.
  always_ff @(posedge clk) begin
    if (res) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      ser_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      idx_q <= idx_d;
      ser_q <= ser_d;
    end
  end

  assign ser_o      = ser_q;
  assign last_bit_o = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first with
// optional repetitions separated by zero-filled gaps. All outputs are registered.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] rep,
  input  logic [CNT_W-1:0] gap,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             capture, reload, shift;
  logic             last_bit;
  logic [LEN_W-1:0] len_norm;

  assign len_norm = LEN_W'(normalise_len(32'(len), PAT_W));

  seq_piso #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_piso (
    .clk       (clk),
    .res       (res),
    .capture_i (capture),
    .reload_i  (reload),
    .shift_i   (shift),
    .pat_i     (pat),
    .len_i     (len_norm),
    .ser_o     (dout),
    .last_bit_o(last_bit)
  );

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    dvalid_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    capture   = 1'b0;
    reload    = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          gap_d    = gap;
          rep_d    = (rep == '0) ? '0 : rep - CNT_W'(1);
          state_d  = SEND;
          dvalid_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SEND: begin
        busy_d = 1'b1;
        if (!last_bit) begin
          shift    = 1'b1;
          dvalid_d = 1'b1;
        end else if (rep_q != '0) begin
          dvalid_d = 1'b1;
          if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q - CNT_W'(1);
          end else begin
            reload = 1'b1;
            rep_d  = rep_q - CNT_W'(1);
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        busy_d   = 1'b1;
        dvalid_d = 1'b1;
        // gap_cnt_q counts gap cycles still to come after the current one.
        if (gap_cnt_q == '0) begin
          reload  = 1'b1;
          rep_d   = rep_q - CNT_W'(1);
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a reference model pushes the expected per-cycle
// {busy, dvalid, dout, done} tuples into a queue; each scenario pops and compares.
module tb_seq_pattern_gen;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef struct packed {
    logic busy;
    logic dvalid;
    logic dout;
    logic done;
  } obs_t;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] rep;
  logic [CNT_W-1:0] gap;
  logic             dout, dvalid, busy, done;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  seq_pattern_gen #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk   (clk),
    .res   (res),
    .start (start),
    .pat   (pat),
    .len   (len),
    .rep   (rep),
    .gap   (gap),
    .dout  (dout),
    .dvalid(dvalid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return obs_t'({busy, dvalid, dout, done});
  endfunction

  // Reference model: expected cycles from the first bit through one trailing IDLE cycle.
  task automatic push_stream(input logic [PAT_W-1:0] p, input int l, input int r, input int g);
    int nl, nr;
    nl = (l == 0 || l > PAT_W) ? PAT_W : l;
    nr = (r == 0) ? 1 : r;
    for (int ri = 0; ri < nr; ri++) begin
      for (int b = nl - 1; b >= 0; b--) exp_q.push_back(obs_t'({1'b1, 1'b1, p[b], 1'b0}));
      if (ri < nr - 1)
        for (int gi = 0; gi < g; gi++) exp_q.push_back(obs_t'(4'b1100));
    end
    exp_q.push_back(obs_t'(4'b1001));
    exp_q.push_back(obs_t'(4'b0000));
  endtask

  // Called at a negedge: presents one request for one edge and records its expected stream.
  task automatic launch(input logic [PAT_W-1:0] p, input int l, input int r, input int g);
    pat   = p;
    len   = LEN_W'(l);
    rep   = CNT_W'(r);
    gap   = CNT_W'(g);
    start = 1'b1;
    push_stream(p, l, r, g);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    res = 1'b1; start = 1'b0; pat = '0; len = '0; rep = '0; gap = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(obs_t'(4'b0000));
    res = 1'b0;
    got = sample();
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset: busy/dvalid/dout/done got %b want %b", got, e);
    end
  endtask

  task automatic test_basic();
    obs_t got, e;
    int n;
    launch(8'b0000_0101, 3, 1, 0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL basic cycle %0d: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_repeat_gap();
    obs_t got, e;
    int n, busy_cycles;
    busy_cycles = 0;
    launch(8'hA5, 0, 2, 2);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      if (got.busy) busy_cycles++;
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL repeat_gap cycle %0d: got %b want %b", i, got, e);
      end
    end
    n_vec++;
    if (busy_cycles !== 19) begin
      n_err++;
      $display("FAIL repeat_gap busy length: got %0d want 19", busy_cycles);
    end
  endtask

  task automatic test_normalise();
    obs_t got, e;
    int n;
    launch(8'h3C, 9, 0, 5);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL normalise cycle %0d: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    pat = 8'b10; len = LEN_W'(2); rep = CNT_W'(1); gap = '0; start = 1'b1;
    push_stream(8'b10, 2, 1, 0);
    @(posedge clk);
    // start stays high; this change must not affect the stream in flight.
    #1 pat = 8'b01;
    push_stream(8'b01, 2, 1, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", i, got, e);
      end
      if (i == 3) begin
        @(posedge clk);
        #1 begin start = 1'b0; pat = 8'hFF; len = '0; rep = CNT_W'(3); end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    int n;
    launch(8'hC3, 8, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid bit %0d: got %b want %b", i, got, e);
      end
    end
    res = 1'b1;
    exp_q.delete();
    exp_q.push_back(obs_t'(4'b0000));
    @(negedge clk);
    res = 1'b0;
    got = sample();
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset_mid abort: got %b want %b", got, e);
    end
    launch(8'h96, 8, 1, 0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid restart cycle %0d: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_res_start();
    obs_t got, e;
    pat = 8'hFF; len = '0; rep = CNT_W'(1); gap = '0;
    res = 1'b1; start = 1'b1;
    exp_q.push_back(obs_t'(4'b0000));
    exp_q.push_back(obs_t'(4'b0000));
    @(posedge clk);
    #1 begin res = 1'b0; start = 1'b0; end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL res_start cycle %0d: got %b want %b", i, got, e);
      end
    end
  endtask

  task automatic test_random();
    obs_t got, e;
    int n;
    for (int t = 0; t < 8; t++) begin
      launch(PAT_W'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        got = sample();
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL random %0d cycle %0d: got %b want %b", t, i, got, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_gap();
    test_normalise();
    test_back_to_back();
    test_reset_mid();
    test_res_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
